// File: rtl/conv_subblock_interleaver_pkg.sv
// conv_intlv_pkg: shared constants for the convolutional sub-block interleaver.
//   C         : number of matrix columns (32)
//   PERM      : column read order, PERM[j] is the matrix column read at step j
//   N_* / R_* : bytes per stream and matrix rows for the two block sizes
//   state_t   : interleaver control states
package conv_intlv_pkg;

    localparam int unsigned C       = 32;
    localparam int unsigned D_SHORT = 1056;
    localparam int unsigned D_LONG  = 6144;

    localparam logic [9:0] N_SHORT = 10'd132;
    localparam logic [9:0] N_LONG  = 10'd768;
    localparam logic [7:0] R_SHORT = 8'd33;
    localparam logic [7:0] R_LONG  = 8'd192;

    localparam logic [4:0] PERM [C] = '{
        5'd1,  5'd17, 5'd9,  5'd25, 5'd5,  5'd21, 5'd13, 5'd29,
        5'd3,  5'd19, 5'd11, 5'd27, 5'd7,  5'd23, 5'd15, 5'd31,
        5'd0,  5'd16, 5'd8,  5'd24, 5'd4,  5'd20, 5'd12, 5'd28,
        5'd2,  5'd18, 5'd10, 5'd26, 5'd6,  5'd22, 5'd14, 5'd30
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_READ,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // One-hot byte-lane write enable for a byte landing in lane 0..3 of a row.
    function automatic logic [3:0] lane_we(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/conv_subblock_interleaver_if.sv
// conv_subblock_interleaver_if: output byte bus towards rate matching.
//   out0..out2 : interleaved bytes of stream 0/1/2
//   out_valid  : out0..out2 hold a valid byte
//   out_ready  : sink accepts when out_valid && out_ready
// master = interleaver side, slave = rate-matching side.
interface conv_subblock_interleaver_if;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic       out_valid;
    logic       out_ready;

    modport master (output out0, output out1, output out2, output out_valid,
                    input  out_ready);
    modport slave  (input  out0, input  out1, input  out2, input  out_valid,
                    output out_ready);
endinterface

// File: rtl/conv_subblock_interleaver_row_ram.sv
// intlv_row_ram: 192 x 32-bit row store for one interleaver stream.
//   clk   : clock
//   we    : per-byte-lane write enables (lane l = bits 8l..8l+7)
//   waddr : write row, wdata : write data (replicated byte per lane)
//   re    : read enable; rdata holds its value while re is low
//   raddr : read row, rdata : row data one cycle after re
module intlv_row_ram (
    input  logic        clk,
    input  logic [3:0]  we,
    input  logic [7:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic [7:0]  raddr,
    output logic [31:0] rdata
);
    logic [31:0] mem [0:191];

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < 4; l++) begin
            if (we[l]) mem[waddr][8*l +: 8] <= wdata[8*l +: 8];
        end
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/conv_subblock_interleaver.sv
// conv_subblock_interleaver: drains the three encoder FIFOs into per-stream
// R x 32 bit matrices (row-wise, LSB-first) and reads them back column-wise
// in PERM order, packing bits LSB-first into bytes on a valid/ready bus.
//   clk, reset      : clock, synchronous active-high reset
//   enc_done        : encoder done level, rising edge starts a block
//   enc_length      : 0 -> 1056-bit block, 1 -> 6144-bit block
//   q0..q2          : encoder FIFO data, valid the cycle after rdreq_subblock
//   rdreq_subblock  : FIFO read strobe (all three streams)
//   ob              : output byte bus (out0..2, out_valid, out_ready)
//   length_out      : block length flag latched at start
//   blk_done        : one-cycle pulse after the last byte is accepted
//   busy            : high outside IDLE
module conv_subblock_interleaver
    import conv_intlv_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enc_done,
    input  logic                               enc_length,
    input  logic [7:0]                         q0,
    input  logic [7:0]                         q1,
    input  logic [7:0]                         q2,
    output logic                               rdreq_subblock,
    conv_subblock_interleaver_if.master        ob,
    output logic                               length_out,
    output logic                               blk_done,
    output logic                               busy
);
    state_t      state, state_next;
    logic        enc_done_d;
    logic [9:0]  byte_cnt;
    logic [7:0]  row_cnt;
    logic [4:0]  col_cnt;
    logic        wr_en_d;
    logic [9:0]  wr_byte;
    logic        s1_valid;
    logic [4:0]  s1_col;
    logic [2:0]  bit_cnt;
    logic [7:0]  sr [3];
    logic [7:0]  qv [3];
    logic [31:0] rdata [3];
    logic [2:0]  bit_in;
    logic [9:0]  last_byte;
    logic [7:0]  last_row;
    logic        start, stall, issue, shift, byte_done;

    always_comb begin
        qv[0] = q0;
        qv[1] = q1;
        qv[2] = q2;
        for (int unsigned i = 0; i < 3; i++) bit_in[i] = rdata[i][s1_col];
    end

    assign last_byte = length_out ? (N_LONG - 10'd1) : (N_SHORT - 10'd1);
    assign last_row  = length_out ? (R_LONG - 8'd1)  : (R_SHORT - 8'd1);
    assign start     = enc_done && !enc_done_d;
    // A pending unaccepted byte freezes address issue, RAM read and packer
    // together, so the RAM output register keeps the bit the packer needs.
    assign stall     = ob.out_valid && !ob.out_ready;
    assign issue     = (state == ST_READ) && !stall;
    assign shift     = s1_valid && !stall;
    assign byte_done = shift && (bit_cnt == 3'd7);

    for (genvar g = 0; g < 3; g++) begin : g_ram
        intlv_row_ram u_ram (
            .clk   (clk),
            .we    (wr_en_d ? lane_we(wr_byte[1:0]) : 4'b0000),
            .waddr (wr_byte[9:2]),
            .wdata ({4{qv[g]}}),
            .re    (issue),
            .raddr (row_cnt),
            .rdata (rdata[g])
        );
    end

    always_comb begin
        state_next     = state;
        rdreq_subblock = (state == ST_FILL);
        busy           = (state != ST_IDLE);
        blk_done       = (state == ST_DONE);
        case (state)
            ST_IDLE:  if (start) state_next = ST_FILL;
            ST_FILL:  if (byte_cnt == last_byte) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_READ;
            ST_READ:  if (issue && row_cnt == last_row && col_cnt == 5'd31)
                          state_next = ST_FLUSH;
            // s1_valid low means the final bit is already packed into out*.
            ST_FLUSH: if (!s1_valid && ob.out_valid && ob.out_ready)
                          state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            enc_done_d   <= 1'b1;   // a level already high at reset release is not an edge
            length_out   <= 1'b0;
            byte_cnt     <= '0;
            row_cnt      <= '0;
            col_cnt      <= '0;
            wr_en_d      <= 1'b0;
            wr_byte      <= '0;
            s1_valid     <= 1'b0;
            s1_col       <= '0;
            bit_cnt      <= '0;
            ob.out0      <= '0;
            ob.out1      <= '0;
            ob.out2      <= '0;
            ob.out_valid <= 1'b0;
        end else begin
            state      <= state_next;
            enc_done_d <= enc_done;
            if (state == ST_IDLE && start) length_out <= enc_length;

            wr_en_d <= rdreq_subblock;
            wr_byte <= byte_cnt;
            byte_cnt <= (state == ST_FILL) ? byte_cnt + 10'd1 : '0;

            if (issue) begin
                if (row_cnt == last_row) begin
                    row_cnt <= '0;
                    col_cnt <= col_cnt + 5'd1;
                end else begin
                    row_cnt <= row_cnt + 8'd1;
                end
            end else if (state != ST_READ) begin
                row_cnt <= '0;
                col_cnt <= '0;
            end

            if (!stall) begin
                s1_valid <= issue;
                s1_col   <= PERM[col_cnt];
            end

            if (shift) bit_cnt <= bit_cnt + 3'd1;

            if (byte_done) begin
                ob.out0      <= {bit_in[0], sr[0][7:1]};
                ob.out1      <= {bit_in[1], sr[1][7:1]};
                ob.out2      <= {bit_in[2], sr[2][7:1]};
                ob.out_valid <= 1'b1;
            end else if (ob.out_valid && ob.out_ready) begin
                ob.out_valid <= 1'b0;
            end
        end
    end

    // Bits enter at the MSB and move down, so the first bit ends in bit 0.
    always_ff @(posedge clk) begin
        if (shift) begin
            for (int unsigned i = 0; i < 3; i++) sr[i] <= {bit_in[i], sr[i][7:1]};
        end
    end
endmodule
